// File: rtl/pc_branch_ctrl.sv
// Program counter and control-flow unit: evaluates B/BR conditions on the
// bypassed VNZ flags, supplies PC+2 for PCS, and implements the sticky HLT state.
module pc_branch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        instr_valid,
    input  logic [3:0]  opcode,
    input  logic [2:0]  ccc,
    input  logic [8:0]  imm9,
    input  logic [15:0] br_target,
    input  logic [2:0]  F,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        taken,
    output logic        flush,
    output logic        halted
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_next;
    logic        cond;
    logic        flag_v;
    logic        flag_n;
    logic        flag_z;

    assign {flag_v, flag_n, flag_z} = F;
    assign pc_plus2 = pc + 16'd2;
    assign halted   = (state == HALT);

    always_comb begin
        cond = 1'b0;
        case (ccc)
            3'b000: cond = ~flag_z;
            3'b001: cond = flag_z;
            3'b010: cond = ~flag_z & ~flag_n;
            3'b011: cond = flag_n;
            3'b100: cond = flag_z | (~flag_z & ~flag_n);
            3'b101: cond = flag_n | flag_z;
            3'b110: cond = flag_v;
            default: cond = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        taken      = 1'b0;
        if (state == RUN) begin
            taken = instr_valid & ((opcode == OP_B) | (opcode == OP_BR)) & cond;
            if (instr_valid & ~stall) begin
                if (opcode == OP_HLT) begin
                    state_next = HALT;
                end else if (taken && opcode == OP_B) begin
                    // word offset: sign-extend imm9 and scale by 2
                    pc_next = pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
                end else if (taken) begin
                    pc_next = br_target & 16'hFFFE;
                end else begin
                    pc_next = pc_plus2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
            flush <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            flush <= taken & ~stall;
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboard bench for pc_branch_ctrl: directed plan items plus random traffic,
// checked against an instruction-level model of the PC and halt state.
module tb_pc_branch_ctrl;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        instr_valid = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [2:0]  ccc = 3'd0;
    logic [8:0]  imm9 = 9'd0;
    logic [15:0] br_target = 16'd0;
    logic [2:0]  F = 3'd0;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        flush;
    logic        halted;

    pc_branch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .instr_valid(instr_valid),
        .opcode(opcode), .ccc(ccc), .imm9(imm9), .br_target(br_target), .F(F),
        .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .flush(flush), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic tk; logic [15:0] p2; } comb_t;
    typedef struct { logic [15:0] pc; logic fl; logic hl; } reg_t;
    comb_t comb_q[$];
    reg_t  reg_q[$];

    int checks = 0;
    int errors = 0;

    int unsigned m_pc = 0;
    bit          m_halt = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // condition table with V=f[2], N=f[1], Z=f[0]
    function automatic bit cond_ok(input int unsigned c, input int unsigned f);
        bit v = f[2], n = f[1], z = f[0];
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || (!z && !n);
            5: return n || z;
            6: return v;
            default: return 1;
        endcase
    endfunction

    task automatic step(input bit v, input int unsigned op, input int unsigned c,
                        input int unsigned imm, input int unsigned tgt,
                        input int unsigned f, input bit st);
        comb_t ce;
        reg_t  re;
        bit    tk;
        int    off;
        @(negedge clk);
        instr_valid = v; opcode = op[3:0]; ccc = c[2:0]; imm9 = imm[8:0];
        br_target = tgt[15:0]; F = f[2:0]; stall = st;
        tk = !m_halt && v && (op == 12 || op == 13) && cond_ok(c, f);
        ce.tk = tk;
        ce.p2 = 16'((m_pc + 2) % 65536);
        comb_q.push_back(ce);
        if (!m_halt && v && !st) begin
            if (op == 15) m_halt = 1;
            else if (tk && op == 12) begin
                off = (imm >= 256) ? int'(imm) - 512 : int'(imm);
                m_pc = int'(unsigned'((int'(m_pc) + 2 + 2 * off) & 32'hFFFF));
            end else if (tk) m_pc = (tgt % 65536) / 2 * 2;
            else m_pc = (m_pc + 2) % 65536;
        end
        re.pc = 16'(m_pc);
        re.fl = tk && !st;
        re.hl = m_halt;
        reg_q.push_back(re);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        instr_valid = 0; stall = 0;
        #3 rst_n = 0;
        #1;
        check("async_reset_pc", pc, RST_PC);
        check("async_reset_halted", halted, 0);
        check("async_reset_flush", flush, 0);
        @(negedge clk);
        rst_n = 1;
        m_pc = RST_PC;
        m_halt = 0;
    endtask

    initial begin : monitor
        comb_t ce;
        reg_t  re;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                ce = comb_q.pop_front();
                check("taken", taken, ce.tk);
                check("pc_plus2", pc_plus2, ce.p2);
            end
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                re = reg_q.pop_front();
                check("pc", pc, re.pc);
                check("flush", flush, re.fl);
                check("halted", halted, re.hl);
            end
        end
    end

    initial begin
        #12;
        check("reset_pc", pc, RST_PC);
        check("reset_flush", flush, 0);
        check("reset_halted", halted, 0);
        @(negedge clk);
        rst_n = 1;
        m_pc = RST_PC;
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 13, 7, 0, 16'h0010, 0, 0);
        step(1, 12, 1, 9'h1FD, 0, 3'b001, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 13, 7, 0, 16'h0010, 0, 0);
        step(1, 12, 1, 9'h1FD, 0, 3'b000, 0);
        step(1, 13, 7, 0, 16'h1235, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 8; f++)
                step(1, 12, c, 9'h002, 0, f, 0);
        step(1, 13, 7, 0, 16'hFFFE, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 13, 7, 0, 16'h0004, 0, 0);
        step(1, 14, 0, 0, 0, 0, 0);
        step(1, 13, 3, 0, 16'h00A0, 3'b010, 1);
        step(1, 15, 0, 0, 0, 0, 1);
        step(1, 15, 0, 0, 0, 0, 1);
        step(1, 15, 0, 0, 0, 0, 0);
        step(1, 12, 7, 9'h010, 0, 0, 0);
        step(1, 13, 7, 0, 16'h4444, 0, 0);
        mid_reset();
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            op = $urandom_range(0, 13);
            if ($urandom_range(0, 7) == 0) op = 14;
            if ($urandom_range(0, 60) == 0) op = 15;
            step($urandom_range(0, 5) != 0, op, $urandom_range(0, 7), $urandom_range(0, 511),
                 $urandom_range(0, 65535), $urandom_range(0, 7), $urandom_range(0, 4) == 0);
            if (m_halt && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                mid_reset();
            end
        end
        for (int i = 0; i < 10 && (reg_q.size() > 0 || comb_q.size() > 0); i++)
            @(posedge clk);
        #3;
        check("queues_drained", reg_q.size() + comb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
